// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready stream multiplexer with one registered
// output stage. The grant comes either from an explicit select or from a
// round-robin search that starts at a rotating pointer.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_valid  per-channel words and valids; in_ready is the accept strobe
//   sel               explicit channel select (RR_MODE=0 only)
//   out_data/out_chan registered word and the id of the channel that supplied it
//   out_valid         output register holds a word; out_ready drains it
module stream_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 0,
  localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SW-1:0]             sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SW-1:0]      ptr;
  logic [SW-1:0]      grant;
  logic               grant_valid;
  logic               can_accept;
  logic               transfer;
  logic [2**SW-1:0]   valid_pad;

  assign can_accept = !out_valid || out_ready;
  assign transfer   = grant_valid && can_accept;

  always_comb begin : arb
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    // Zero padding makes an out-of-range select look like an idle channel.
    valid_pad                 = '0;
    valid_pad[CHANNELS-1:0]   = in_valid;
    if (RR_MODE == 0) begin
      if (valid_pad[sel]) begin
        grant       = sel;
        grant_valid = 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!grant_valid && in_valid[idx]) begin
          grant       = SW'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && transfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (transfer) begin
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_chan  <= grant;
      out_valid <= 1'b1;
      if (RR_MODE != 0)
        ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [1:0]   sel;
  logic         out_ready;

  logic [3:0]  r0, r1;
  logic [2:0]  r3;
  logic [31:0] d0, d1, d3;
  logic [1:0]  c0, c1, c3;
  logic        v0, v1, v3;

  int passed = 0;
  int total  = 0;

  // dut index 0: explicit select, 4 channels; 1: round-robin, 4 channels;
  // 2: explicit select, 3 channels
  logic        m_valid [3];
  logic [31:0] m_data  [3];
  int          m_chan  [3];
  int          m_ptr   [3];

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(32), .CHANNELS(4), .RR_MODE(0)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r0), .sel(sel), .out_data(d0), .out_chan(c0),
    .out_valid(v0), .out_ready(out_ready));

  stream_mux #(.WIDTH(32), .CHANNELS(4), .RR_MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r1), .sel(sel), .out_data(d1), .out_chan(c1),
    .out_valid(v1), .out_ready(out_ready));

  stream_mux #(.WIDTH(32), .CHANNELS(3), .RR_MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
    .in_ready(r3), .sel(sel), .out_data(d3), .out_chan(c3),
    .out_valid(v3), .out_ready(out_ready));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Model: compares current outputs, then advances by the transfer rules
  // using the inputs that will be present at the coming rising edge.
  task automatic model_cycle(input int id, input int mode, input int nch,
                             input logic gv, input logic [31:0] gd,
                             input logic [1:0] gc, input logic [3:0] gr);
    int g;
    logic [3:0] exp_r;
    logic can;
    if (!rst_n) begin
      m_valid[id] = 1'b0; m_data[id] = 0; m_chan[id] = 0; m_ptr[id] = 0;
    end
    check($sformatf("dut%0d out_valid", id), 64'(gv), 64'(m_valid[id]));
    check($sformatf("dut%0d out_data", id), 64'(gd), 64'(m_data[id]));
    check($sformatf("dut%0d out_chan", id), 64'(gc), 64'(m_chan[id]));
    g = -1;
    if (mode == 0) begin
      if (int'(sel) < nch && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = nch - 1; k >= 0; k--)
        if (in_valid[(m_ptr[id] + k) % nch]) g = (m_ptr[id] + k) % nch;
    end
    can = !m_valid[id] || out_ready;
    exp_r = (rst_n && can && g >= 0) ? 4'(1 << g) : 4'b0;
    check($sformatf("dut%0d in_ready", id), 64'(gr), 64'(exp_r));
    if (!rst_n) return;
    if (can && g >= 0) begin
      m_valid[id] = 1'b1;
      m_data[id]  = in_data[g*32 +: 32];
      m_chan[id]  = g;
      if (mode == 1) m_ptr[id] = (g + 1) % nch;
    end else if (out_ready) begin
      m_valid[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, 0, 4, v0, d0, c0, r0);
    model_cycle(1, 1, 4, v1, d1, c1, r1);
    model_cycle(2, 0, 3, v3, d3, c3, {1'b0, r3});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
    repeat (3) step();
    check("reset out_valid", 64'({v0, v1, v3}), 64'd0);
    check("reset out_data", 64'(d0 | d1 | d3), 64'd0);
    check("reset in_ready", 64'({r0, r1, r3}), 64'd0);

    // round-robin sequence from pointer 0; first transfer on first edge out of reset
    rst_n = 1'b1;
    in_data = {32'd3, 32'd2, 32'd1, 32'd0};
    in_valid = 4'b1111; out_ready = 1'b1; sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr seq chan %0d", i), 64'(c1), 64'(i % 4));
      check($sformatf("rr seq data %0d", i), 64'(d1), 64'(i % 4));
      check($sformatf("rr seq valid %0d", i), 64'(v1), 64'd1);
    end
    in_valid = 4'b0000;
    in_data = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    step();

    // explicit select of channel 2
    sel = 2'd2; in_valid = 4'b0100;
    step();
    check("sel2 out_valid", 64'(v0), 64'd1);
    check("sel2 out_data", 64'(d0), 64'hDEADBEEF);
    check("sel2 out_chan", 64'(c0), 64'd2);
    in_valid = 4'b0000;
    step();
    check("drain out_valid", 64'(v0), 64'd0);
    check("drain data hold", 64'(d0), 64'hDEADBEEF);

    // round-robin wrap: pointer is 3 here
    in_valid = 4'b1001;
    step();
    check("wrap first chan", 64'(c1), 64'd3);
    step();
    check("wrap second chan", 64'(c1), 64'd0);
    in_valid = 4'b1111;
    step();
    check("ptr after wrap", 64'(c1), 64'd1);

    // backpressure with a full register
    out_ready = 1'b0; in_valid = 4'b0011;
    #1 check("bp in_ready", 64'(r1), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp data %0d", i), 64'(d1), 64'h22222222);
      check($sformatf("bp valid %0d", i), 64'(v1), 64'd1);
      check($sformatf("bp ready %0d", i), 64'(r1), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", 64'(r1), 64'b0001);
    step();
    check("bp no bubble data", 64'(d1), 64'h11111111);
    check("bp no bubble valid", 64'(v1), 64'd1);

    // out-of-range select on the 3-channel instance
    in_valid = 4'b0000;
    step();
    sel = 2'd3; in_valid = 4'b1111;
    #1 check("oor in_ready", 64'(r3), 64'd0);
    step();
    check("oor out_valid a", 64'(v3), 64'd0);
    step();
    check("oor out_valid b", 64'(v3), 64'd0);

    // asynchronous reset between edges
    in_data[63:32] = 32'h12345678; sel = 2'd1; in_valid = 4'b0010;
    step();
    check("pre-reset data", 64'(d0), 64'h12345678);
    out_ready = 1'b0; in_valid = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("async rst valid", 64'(v0), 64'd0);
    check("async rst data", 64'(d0), 64'd0);
    check("async rst chan", 64'(c0), 64'd0);
    check("async rst in_ready", 64'({r0, r1, r3}), 64'd0);
    step();
    rst_n = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; sel = 2'd0;
    step();
    check("ptr after reset", 64'(c1), 64'd0);
    in_valid = 4'b0000;
    repeat (2) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data bits per channel.
REQ-002 SHALL provide parameter CHANNELS, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL provide parameter RR_MODE, default 0; 0 = explicit select, 1 = round-robin arbitration.
REQ-004 SHALL define SW = max(1, ceil(log2(CHANNELS))) as the select/channel-id width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 in_ready  output  CHANNELS  per-channel accept strobe; combinational.
REQ-010 sel  input  SW  channel select; used only when RR_MODE=0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SW  registered id of the channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-015 SHALL hold a single-entry output register (out_data, out_chan, out_valid).
REQ-016 can_accept SHALL be (!out_valid) OR (out_valid AND out_ready); a full register draining in the same cycle accepts a new word with no bubble.
REQ-017 RR_MODE=0: grant SHALL be channel sel when sel < CHANNELS and in_valid[sel]=1; otherwise no grant.
REQ-018 RR_MODE=1: grant SHALL be the first channel with in_valid=1 searching ptr, ptr+1, ..., wrapping CHANNELS-1 -> 0; no grant if no in_valid set.
REQ-019 in_ready[i] SHALL be 1 only for i = grant and only when can_accept=1; at most one bit set per cycle.
REQ-020 Transfer on channel i SHALL occur when in_valid[i] AND in_ready[i]; next cycle out_data = in_data slice i, out_chan = i, out_valid = 1 (latency 1 cycle).
REQ-021 When out_valid AND out_ready and no input transfer, out_valid SHALL clear next cycle; out_data/out_chan hold their last values.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_chan, out_valid SHALL remain stable.
REQ-023 RR pointer ptr (SW bits) SHALL update to (grant+1) mod CHANNELS only on a transfer; unchanged otherwise; from CHANNELS-1 wraps to 0.
REQ-024 RR_MODE=0 SHALL not use ptr; it stays 0.
REQ-025 sel and in_valid changes SHALL take effect combinationally in the same cycle; no registered select.
REQ-026 Non-power-of-two CHANNELS: ptr SHALL never exceed CHANNELS-1.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 in_ready SHALL be 0 while rst_n=0.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight word; first transfer after release occurs on the first rising edge with rst_n=1.

Verification
REQ-030 RR_MODE=0, CHANNELS=4: sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=32'hDEADBEEF, out_chan=2.
REQ-031 RR_MODE=1, in_valid=4'b1111 held, out_ready=1, ch i data=i -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-032 Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b0011 -> in_ready=0, out_data unchanged all 5 cycles; out_ready=1 on cycle 6 -> new word loaded same edge, no bubble.
REQ-033 RR fairness/wrap: ptr=3, in_valid=4'b1001 -> grant 3 then 0; ptr after second transfer = 1.
REQ-034 RR_MODE=0, CHANNELS=3, sel=3 with in_valid=3'b111 -> in_ready=0, out_valid stays 0.
REQ-035 Assert rst_n=0 between clock edges while out_valid=1, out_data=32'h12345678 -> out_valid=0, out_data=0, out_chan=0 before the next edge; ptr=0 after release.
